// File: rtl/timeout_pkg.sv
// Shared types for the timeout-timer initiator: FSM state encoding and default budget width.
package timeout_pkg;

    localparam int unsigned DefaultW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/timeout_waiter.sv
// Initiator for the shared timeout timer: arms it with a budget, reports event vs expiry.
// Define TIMEOUT_WAITER_RETRY_EN to re-arm up to RETRIES times before reporting a timeout.
module timeout_waiter
    import timeout_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned RETRIES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_count,
    input  logic         evt,          // "event" is a reserved word
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_timeout,
    output logic [W-1:0] tmr_count,
    output logic         tmr_put,
    input  logic         tmr_full
`ifdef TIMEOUT_WAITER_RETRY_EN
    ,
    output logic [$clog2(RETRIES+2)-1:0] resp_tries
`endif
);

    state_e         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_timeout_q, resp_timeout_d;
    logic           tmr_put_q, tmr_put_d;
    logic [W-1:0]   tmr_count_q, tmr_count_d;

`ifdef TIMEOUT_WAITER_RETRY_EN
    localparam int unsigned TW = $clog2(RETRIES + 2);
    logic [TW-1:0] tries_q, tries_d;
    logic          rearm;

    assign rearm = (tries_q <= TW'(RETRIES));
`else
    logic unused_retries;
    logic rearm;

    // RETRIES only matters when re-arming is built in
    assign unused_retries = ^RETRIES;
    assign rearm          = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        resp_timeout_d = resp_timeout_q;
        tmr_count_d    = tmr_count_q;
`ifdef TIMEOUT_WAITER_RETRY_EN
        tries_d        = tries_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    tmr_count_d = req_count;
                    state_d     = ARM;
`ifdef TIMEOUT_WAITER_RETRY_EN
                    tries_d     = TW'(1);
`endif
                end
            end
            ARM: begin
                if (evt) begin
                    state_d        = DONE;
                    resp_timeout_d = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Event wins over an expiry seen in the same cycle
                if (evt) begin
                    state_d        = DONE;
                    resp_timeout_d = 1'b0;
                end else if (!tmr_full) begin
                    if (rearm) begin
                        state_d = ARM;
`ifdef TIMEOUT_WAITER_RETRY_EN
                        tries_d = tries_q + TW'(1);
`endif
                    end else begin
                        state_d        = DONE;
                        resp_timeout_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        tmr_put_d    = (state_d == ARM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            tmr_put_q      <= 1'b0;
            tmr_count_q    <= '0;
`ifdef TIMEOUT_WAITER_RETRY_EN
            tries_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            tmr_put_q      <= tmr_put_d;
            tmr_count_q    <= tmr_count_d;
`ifdef TIMEOUT_WAITER_RETRY_EN
            tries_q        <= tries_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_timeout = resp_timeout_q;
    assign tmr_put      = tmr_put_q;
    assign tmr_count    = tmr_count_q;
`ifdef TIMEOUT_WAITER_RETRY_EN
    assign resp_tries   = tries_q;
`endif

endmodule

// File: tb/tb_timeout_waiter.sv
// Bench for timeout_waiter with a behavioural down-counting timer; honours TIMEOUT_WAITER_RETRY_EN.
module tb_timeout_waiter;
    import timeout_pkg::*;

    localparam int unsigned W       = DefaultW;
    localparam int unsigned RETRIES = 2;
`ifdef TIMEOUT_WAITER_RETRY_EN
    localparam int Arms = RETRIES + 1;
`else
    localparam int Arms = 1;
`endif

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_count;
    logic         evt;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_timeout;
    logic [W-1:0] tmr_count;
    logic         tmr_put;
    logic         tmr_full;
    logic [W-1:0] tmr_rem;
`ifdef TIMEOUT_WAITER_RETRY_EN
    logic [$clog2(RETRIES+2)-1:0] resp_tries;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    timeout_waiter #(
        .W       (W),
        .RETRIES (RETRIES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_count    (req_count),
        .evt          (evt),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_timeout (resp_timeout),
        .tmr_count    (tmr_count),
        .tmr_put      (tmr_put),
        .tmr_full     (tmr_full)
`ifdef TIMEOUT_WAITER_RETRY_EN
        ,
        .resp_tries   (resp_tries)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Timer: a put loads the budget; full stays high for exactly that many cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_rem <= '0;
        end else if (tmr_put) begin
            tmr_rem <= tmr_count;
        end else if (tmr_rem != '0) begin
            tmr_rem <= tmr_rem - 1'b1;
        end
    end
    assign tmr_full = (tmr_rem != '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One transaction. Cycle 0 is the handshake cycle; e is the cycle of a one-cycle
    // event pulse (negative = none). Every arm spans p = n+2 cycles (ARM + n busy + expiry).
    task automatic run_txn(input int n, input int e, input int hold);
        int  p, last, exp_done, exp_to, exp_tries, t, puts;
        bit  seen, ready_bad, count_bad, stable_bad;
        p    = n + 2;
        last = Arms * p;
        if (e >= 1 && e <= last) begin
            exp_done  = e + 1;
            exp_to    = 0;
            exp_tries = (e - 1) / p + 1;
        end else begin
            exp_done  = last + 1;
            exp_to    = 1;
            exp_tries = Arms;
        end

        check("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_count = W'(n);
        evt       = (e == 0);
        tick();
        req_valid = 1'b0;
        t = 1; puts = 0; seen = 0; ready_bad = 0; count_bad = 0;
        while (t < 2000) begin
            if (resp_valid) begin
                seen = 1;
                break;
            end
            if (req_ready) ready_bad = 1;
            if (tmr_count != W'(n)) count_bad = 1;
            if (tmr_put) puts++;
            evt = (t == e);
            tick();
            t++;
        end
        evt = 1'b0;
        check("resp_seen", seen, 1);
        check("resp_cycle", t, exp_done);
        check("resp_timeout", resp_timeout, exp_to);
        check("tmr_put_pulses", puts, exp_tries);
        check("ready_low_busy", ready_bad, 0);
        check("tmr_count_held", count_bad, 0);
`ifdef TIMEOUT_WAITER_RETRY_EN
        check("resp_tries", resp_tries, exp_tries);
`endif
        stable_bad = 0;
        for (int i = 0; i < hold; i++) begin
            evt = 1'($urandom_range(0, 1));
            tick();
            if (!resp_valid || resp_timeout !== 1'(exp_to) || req_ready) stable_bad = 1;
        end
        if (hold > 0) check("resp_stable", stable_bad, 0);
        evt        = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("ready_back", req_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_timeout"}, resp_timeout, 0);
        check({tag, "_tmr_put"}, tmr_put, 0);
        check({tag, "_tmr_count"}, tmr_count, 0);
`ifdef TIMEOUT_WAITER_RETRY_EN
        check({tag, "_tries"}, resp_tries, 0);
`endif
    endtask

    initial begin
        bit spurious;
        int n, e;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_count  = '0;
        evt        = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;
        tick();

        run_txn(5, -1, 0);
        run_txn(20, 5, 25);
        run_txn(3, Arms * 5, 0);
        run_txn(0, -1, 5);
        run_txn(4, -1, 1);

        // Reset in the middle of a wait
        req_valid = 1'b1;
        req_count = W'(10);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clock);
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (resp_valid || tmr_put || !req_ready) spurious = 1;
        end
        check("no_spurious_after_reset", spurious, 0);

        for (int k = 0; k < 30; k++) begin
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) e = -1;
            else e = $urandom_range(0, Arms * (n + 2) + 3);
            run_txn(n, e, $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
